// File: rtl/score_argmax_pkg.sv
// Shared types and defaults for the score_argmax classifier head.
package score_argmax_pkg;

  localparam int unsigned DEF_NUM_CLASSES = 10;
  localparam int unsigned DEF_SCORE_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // Index width; a single class still needs a one-bit index port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/score_argmax.sv
// Sequential argmax over a snapshot of network scores, one class per cycle.
// Optional best-minus-second margin and low-confidence flag: SCORE_ARGMAX_MARGIN_EN.
module score_argmax
  import score_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES   = DEF_NUM_CLASSES,
  parameter int unsigned SCORE_W       = DEF_SCORE_W
`ifdef SCORE_ARGMAX_MARGIN_EN
  ,
  parameter int unsigned MARGIN_THRESH = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SCORE_W-1:0]            scores [NUM_CLASSES],
  output logic                          busy,
  output logic                          done,
  output logic [idx_w(NUM_CLASSES)-1:0] class_idx,
  output logic [SCORE_W-1:0]            max_score
`ifdef SCORE_ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W-1:0]            margin,
  output logic                          low_conf
`endif
);

  localparam int unsigned      IDX_W    = idx_w(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   snap_q [NUM_CLASSES];
  logic [SCORE_W-1:0]   snap_d [NUM_CLASSES];
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     class_idx_q, class_idx_d;
  logic [SCORE_W-1:0]   max_score_q, max_score_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SCORE_W-1:0]   cand;
`ifdef SCORE_ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0]   second_q, second_d;
  logic [SCORE_W-1:0]   margin_q, margin_d;
  logic                 low_conf_q, low_conf_d;
`endif

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    idx_d       = idx_q;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;
    cand        = '0;
`ifdef SCORE_ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin_q;
    low_conf_d  = low_conf_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          snap_d     = scores;
          best_d     = scores[0];
          best_idx_d = '0;
          idx_d      = IDX_W'(1);
`ifdef SCORE_ARGMAX_MARGIN_EN
          second_d   = '0;
`endif
          state_d    = SCAN;
        end else begin
          state_d    = IDLE;
        end
      end
      SCAN: begin
        // With one class the scan cycle is empty: snap[0] already holds the answer.
        if (NUM_CLASSES > 1) begin
          cand = snap_q[idx_q];
          if (cand > best_q) begin
`ifdef SCORE_ARGMAX_MARGIN_EN
            second_d   = best_q;
`endif
            best_d     = cand;
            best_idx_d = idx_q;
          end
`ifdef SCORE_ARGMAX_MARGIN_EN
          else if (cand > second_q) begin
            second_d   = cand;
          end
`endif
          idx_d = idx_q + IDX_W'(1);
        end
        if (NUM_CLASSES == 1 || idx_q == LAST_IDX) begin
          state_d     = DONE;
          class_idx_d = best_idx_d;
          max_score_d = best_d;
`ifdef SCORE_ARGMAX_MARGIN_EN
          margin_d    = best_d - second_d;
          low_conf_d  = (32'(margin_d) < MARGIN_THRESH);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) snap_q[i] <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      class_idx_q <= '0;
      max_score_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCORE_ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
      low_conf_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      idx_q       <= idx_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SCORE_ARGMAX_MARGIN_EN
      second_q    <= second_d;
      margin_q    <= margin_d;
      low_conf_q  <= low_conf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign max_score = max_score_q;
`ifdef SCORE_ARGMAX_MARGIN_EN
  assign margin    = margin_q;
  assign low_conf  = low_conf_q;
`endif

endmodule

// File: doc/score_argmax.md
SCORE_ARGMAX -- requirements
Module: score_argmax

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of output scores from the network.
REQ-002 SHALL have parameter SCORE_W, default 8: width of each unsigned score.
REQ-003 SHALL have parameter MARGIN_THRESH, default 16: low-confidence threshold; present only with SCORE_ARGMAX_MARGIN_EN.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to classify the current scores.
REQ-007 SHALL have port scores, input, unpacked array [NUM_CLASSES] of SCORE_W: network output scores, unsigned.
REQ-008 SHALL have port busy, output, 1 bit: scan in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 SHALL have port class_idx, output, IDX_W = $clog2(NUM_CLASSES): winning class.
REQ-011 SHALL have port max_score, output, SCORE_W: winning score.
REQ-012 SHALL have ports margin (output, SCORE_W, best minus second-best) and low_conf (output, 1 bit); present only with SCORE_ARGMAX_MARGIN_EN.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-014 SHALL, on start=1 in IDLE or DONE: snapshot all scores into an internal register, load best=snap[0], best_idx=0, second=0, idx=1, and go to SCAN.
REQ-015 SHALL, in each SCAN cycle, compare snap[idx]; the best is replaced only when snap[idx] is strictly greater, so on ties the lowest index wins.
REQ-016 SHALL go to DONE after the SCAN cycle with idx=NUM_CLASSES-1, i.e. after NUM_CLASSES-1 SCAN cycles.
REQ-017 SHALL assert done in the DONE cycle only, NUM_CLASSES cycles after the edge that sampled start.
REQ-018 SHALL, in DONE, go to SCAN if start=1 and otherwise go to IDLE.
REQ-019 SHALL assert busy only in SCAN.
REQ-020 SHALL ignore start while in SCAN, with no queueing.
REQ-021 SHALL update class_idx, max_score and margin/low_conf on the edge entering DONE and hold them until the next entry to DONE.
REQ-022 SHALL make results depend only on the snapshot; changes to scores after the start edge have no effect.
REQ-023 SHALL, with margin enabled, track the second-best value: if x > best, then second=best and best=x; else if x > second, then second=x.
REQ-024 SHALL compute margin = best - second, which never underflows.
REQ-025 SHALL set low_conf = (margin < MARGIN_THRESH).
REQ-026 SHALL handle NUM_CLASSES=1 by treating the SCAN cycle as empty: go to DONE on the next edge with class 0.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE and busy=0, done=0, class_idx=0, max_score=0, margin=0, low_conf=0, and clear the snapshot.
REQ-028 SHALL abort a scan when reset is asserted mid-scan; no done is produced for the aborted request.
REQ-029 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro SCORE_ARGMAX_MARGIN_EN defined, include second-best tracking, the margin and low_conf ports, and MARGIN_THRESH.
REQ-031 SHALL, without the macro, omit those ports, the parameter and the second-best register; all other timing is identical.

Structure
REQ-032 SHALL place the state enum (IDLE/SCAN/DONE), default NUM_CLASSES and SCORE_W constants, and the IDX_W helper in a shared package score_argmax_pkg.
REQ-033 SHALL be a single module with no sub-module; the compare/update logic is small enough to stay inline.

Verification
REQ-034 SHALL cover: scores={3,7,1,200,5,5,9,0,2,4}, start -> done 10 cycles later, class_idx=3, max_score=200, margin=191, low_conf=0.
REQ-035 SHALL cover: all scores=50 -> class_idx=0, max_score=50, margin=0, low_conf=1.
REQ-036 SHALL cover: scores[9]=255, others 0 -> class_idx=9, max_score=255, margin=255.
REQ-037 SHALL cover: start again on scan cycle 4 with changed scores -> ignored, one done, result of the first request; scores changed after start also do not affect the result.
REQ-038 SHALL cover: rst_n low on scan cycle 5 -> outputs 0, busy=0, no done; a new start after release produces a correct result 10 cycles later.
REQ-039 SHALL cover: start held high continuously -> done every 10 cycles via DONE->SCAN, with busy low only in the DONE cycles.
